// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the synchronous FIFO.
//   - default almost-full / almost-empty thresholds
//   - pointer-width and depth helpers (pointer = address bits + wrap bit)
//   - count type for the default geometry
package fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_AF_LEVEL   = 6;
  localparam int DEF_AE_LEVEL   = 2;
  localparam int DEF_PTR_WIDTH  = DEF_ADDR_WIDTH + 1;

  typedef logic [DEF_PTR_WIDTH-1:0] count_t;

  function automatic int ptr_width(input int aw);
    return aw + 1;
  endfunction

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_mem_dp.sv
// fifo_mem_dp: FIFO storage array.
//   CLK    rising-edge clock
//   RST    asynchronous active-low reset, clears every entry
//   we     write enable (accepted write only)
//   waddr  write address, wdata write data
//   raddr  read address, rdata asynchronous read data
module fifo_mem_dp
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with occupancy count, almost flags,
// read port with valid strobe and sticky overflow/underflow flags.
//   CLK, RST        clock / asynchronous active-low reset
//   w_data, winc    write data and write request
//   rinc            read request (pop acknowledge in FWFT mode)
//   clr_err         synchronous clear of overflow/underflow (set wins)
//   r_data, r_valid read data and valid strobe
//   wfull, rempty, walmost_full, ralmost_empty, count   status
//   overflow, underflow                                 sticky errors
// Build option: SYNC_FIFO_FWFT_EN selects first-word-fall-through reads;
// undefined gives the registered read with latency 1.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = DEF_AF_LEVEL,
  parameter int AE_LEVEL   = DEF_AE_LEVEL
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  winc,
  input  logic                  rinc,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  walmost_full,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                 PTR_W  = ptr_width(ADDR_WIDTH);
  localparam logic [PTR_W-1:0]   AF_CNT = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0]   AE_CNT = PTR_W'(AE_LEVEL);
  localparam logic [PTR_W-1:0]   ONE    = PTR_W'(1);

  logic [PTR_W-1:0]      wptr, rptr;
  logic                  wen, ren;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // Flags come only from the pointer registers, so requests never reach
  // a flag combinationally.
  assign rempty        = (wptr == rptr);
  assign wfull         = (wptr[PTR_W-1] != rptr[PTR_W-1]) &&
                         (wptr[PTR_W-2:0] == rptr[PTR_W-2:0]);
  assign count         = wptr - rptr;
  assign walmost_full  = (count >= AF_CNT);
  assign ralmost_empty = (count <= AE_CNT);

  assign wen = winc && !wfull;
  assign ren = rinc && !rempty;

  fifo_mem_dp #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .CLK   (CLK),
    .RST   (RST),
    .we    (wen),
    .waddr (wptr[PTR_W-2:0]),
    .wdata (w_data),
    .raddr (rptr[PTR_W-2:0]),
    .rdata (mem_rdata)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wen) wptr <= wptr + ONE;
      if (ren) rptr <= rptr + ONE;
    end
  end

  // Set has priority over clear so an error in the clearing cycle is kept.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull)      overflow <= 1'b1;
      else if (clr_err)       overflow <= 1'b0;
      if (rinc && rempty)     underflow <= 1'b1;
      else if (clr_err)       underflow <= 1'b0;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign r_data  = mem_rdata;
  assign r_valid = !rempty;
`else
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= ren;
      if (ren) r_data <= mem_rdata;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
module tb_sync_fifo_ctrl;
  import fifo_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic          winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
  logic [DW-1:0] r_data;
  logic          r_valid, wfull, rempty, walmost_full, ralmost_empty;
  logic [AW:0]   count;
  logic          overflow, underflow;

  sync_fifo_ctrl #(
    .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .AF_LEVEL (AF), .AE_LEVEL (AE)
  ) dut (
    .CLK (CLK), .RST (RST), .w_data (w_data), .winc (winc), .rinc (rinc),
    .clr_err (clr_err), .r_data (r_data), .r_valid (r_valid),
    .wfull (wfull), .rempty (rempty), .walmost_full (walmost_full),
    .ralmost_empty (ralmost_empty), .count (count),
    .overflow (overflow), .underflow (underflow)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] sb_q[$];
  logic          m_ovf = 1'b0, m_unf = 1'b0;
  logic [DW-1:0] m_last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag);
    count_t c;
    c = count_t'(sb_q.size());
    chk({tag, ":count"},     32'(count),         32'(c));
    chk({tag, ":wfull"},     32'(wfull),         32'(sb_q.size() == DEPTH));
    chk({tag, ":rempty"},    32'(rempty),        32'(sb_q.size() == 0));
    chk({tag, ":afull"},     32'(walmost_full),  32'(sb_q.size() >= AF));
    chk({tag, ":aempty"},    32'(ralmost_empty), 32'(sb_q.size() <= AE));
    chk({tag, ":overflow"},  32'(overflow),      32'(m_ovf));
    chk({tag, ":underflow"}, 32'(underflow),     32'(m_unf));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ":r_data"},    32'(r_data),        32'(0));
    chk({tag, ":r_valid"},   32'(r_valid),       32'(0));
    chk({tag, ":wfull"},     32'(wfull),         32'(0));
    chk({tag, ":rempty"},    32'(rempty),        32'(1));
    chk({tag, ":afull"},     32'(walmost_full),  32'(0));
    chk({tag, ":aempty"},    32'(ralmost_empty), 32'(1));
    chk({tag, ":count"},     32'(count),         32'(0));
    chk({tag, ":overflow"},  32'(overflow),      32'(0));
    chk({tag, ":underflow"}, 32'(underflow),     32'(0));
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_last_rd = '0;
  endtask

  // One clock of stimulus; the model decides acceptance from the state at
  // the start of the cycle, then outputs are sampled 1 time unit after the edge.
  task automatic step(input string tag, input logic w, input logic [DW-1:0] wd,
                      input logic r, input logic clr);
    logic full, empty, exp_wen, exp_ren;
    logic [DW-1:0] popped;
    @(negedge CLK);
    winc = w; w_data = wd; rinc = r; clr_err = clr;
    full    = (sb_q.size() == DEPTH);
    empty   = (sb_q.size() == 0);
    exp_wen = w && !full;
    exp_ren = r && !empty;
    popped  = '0;
    @(posedge CLK);
    if (exp_ren) popped = sb_q.pop_front();
    if (exp_wen) sb_q.push_back(wd);
    if (w && full) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
    if (r && empty) m_unf = 1'b1; else if (clr) m_unf = 1'b0;
    #1;
    chk_status(tag);
`ifdef SYNC_FIFO_FWFT_EN
    chk({tag, ":r_valid"}, 32'(r_valid), 32'(sb_q.size() != 0));
    if (sb_q.size() != 0) chk({tag, ":r_data"}, 32'(r_data), 32'(sb_q[0]));
`else
    chk({tag, ":r_valid"}, 32'(r_valid), 32'(exp_ren));
    if (exp_ren) m_last_rd = popped;
    chk({tag, ":r_data"}, 32'(r_data), 32'(m_last_rd));
`endif
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
  endtask

  initial begin
    #12;
    chk_reset("reset");
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 8; i++) step("fill", 1'b1, DW'(8'h11 + i), 1'b0, 1'b0);
    step("write_full", 1'b1, 8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step("drain", 1'b0, '0, 1'b1, 1'b0);
    step("read_empty", 1'b0, '0, 1'b1, 1'b0);
    step("clr_err", 1'b0, '0, 1'b0, 1'b1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 5; i++) step("wrap_wr", 1'b1, DW'(16 * r + i + 8'h40), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step("wrap_rd", 1'b0, '0, 1'b1, 1'b0);
    end

    step("both_empty", 1'b1, 8'hA1, 1'b1, 1'b0);
    step("clr_unf", 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("to4", 1'b1, DW'(8'hB0 + i), 1'b0, 1'b0);
    step("both_mid", 1'b1, 8'hC4, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step("to8", 1'b1, DW'(8'hD0 + i), 1'b0, 1'b0);
    step("both_full", 1'b1, 8'hE0, 1'b1, 1'b0);
    step("clr_ovf", 1'b0, '0, 1'b0, 1'b1);
    step("refill", 1'b1, 8'hE1, 1'b0, 1'b0);
    step("clr_and_ovf", 1'b1, 8'hEE, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step("to5", 1'b0, '0, 1'b1, 1'b0);

    @(posedge CLK);
    #2 RST = 1'b0;
    #1;
    chk_reset("mid_reset");
    model_reset();
    @(negedge CLK);
    RST = 1'b1;

    step("post_wr", 1'b1, 8'h5A, 1'b0, 1'b0);
    step("post_wr2", 1'b1, 8'h5B, 1'b0, 1'b0);
    step("post_rd", 1'b0, '0, 1'b1, 1'b0);
    step("post_rd2", 1'b0, '0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
